zircon_ps2_rx: RTL and testbench
================================

ZIRCON_PS2_RX -- requirements
Module: zircon_ps2_rx

Interface
REQ-001 The block SHALL have parameter FILTER_LEN, default 8, giving the number of consecutive equal synchronized samples needed to accept a new PS/2 clock level.
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 50000, giving the csi_clk cycles without a filtered PS/2 clock falling edge after which a partial frame is abandoned.
REQ-003 The block SHALL use one clock, csi_clk; reset is asynchronous and active-low, named rsi_reset_n.
REQ-004 The block SHALL have port csi_clk, input, 1 bit: system clock.
REQ-005 The block SHALL have port rsi_reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port coe_ps2_clk, input, 1 bit: raw PS/2 clock from the pin.
REQ-007 The block SHALL have port coe_ps2_data, input, 1 bit: raw PS/2 data from the pin.
REQ-008 The block SHALL have port scan_code, output, 8 bits: final scan code byte of the last key event.
REQ-009 The block SHALL have port scan_ext, output, 1 bit: the event was preceded by an E0 prefix.
REQ-010 The block SHALL have port scan_break, output, 1 bit: the event was preceded by an F0 prefix (key release).
REQ-011 The block SHALL have port scan_valid, output, 1 bit: one-cycle strobe marking a complete key event.
REQ-012 The block SHALL have port frame_err, output, 1 bit: one-cycle strobe marking a parity, start-bit, stop-bit or timeout error.

Function
REQ-013 The block SHALL pass coe_ps2_clk and coe_ps2_data through 2-flop synchronizers.
REQ-014 The block SHALL filter the synchronized PS/2 clock: the filtered level changes only after FILTER_LEN consecutive identical samples.
REQ-015 A falling edge SHALL be detected as a filtered-clock transition from 1 to 0; synchronized data SHALL be sampled in that same cycle.
REQ-016 The frame FSM SHALL have the states IDLE, DATA, PARITY and STOP.
- IDLE: on a falling edge, if data is 0 (start bit), go to DATA with bit count 0; if data is 1, pulse frame_err and stay in IDLE.
- DATA: on each falling edge, shift the bit in LSB-first; after the 8th bit go to PARITY.
- PARITY: on a falling edge, capture the parity bit and go to STOP.
- STOP: on a falling edge, check the stop bit and parity, then return to IDLE.
REQ-017 Parity SHALL be odd: the 8 data bits plus the parity bit contain an odd number of ones.
REQ-018 A frame SHALL be accepted when the stop bit is 1 and parity is good; the byte becomes available internally in the cycle after the stop-bit edge.
REQ-019 A stop bit of 0 or bad parity SHALL pulse frame_err for one cycle in the cycle after the stop-bit edge; the byte is discarded.
REQ-020 In any state other than IDLE, a counter SHALL count cycles since the last falling edge; on reaching TIMEOUT_CYC it SHALL pulse frame_err, discard the frame and return to IDLE.
REQ-021 The event decoder SHALL process accepted bytes as follows:
- 0xE0 sets the ext flag.
- 0xF0 sets the brk flag.
- Any other byte (including 0xE1) drives scan_code, scan_ext and scan_break from the byte and flags, pulses scan_valid in the cycle after the byte is accepted, and clears both flags.
- Total latency from the stop-bit edge to scan_valid SHALL be 2 cycles.
REQ-022 Any frame_err SHALL clear both the ext and brk flags.
REQ-023 scan_code, scan_ext and scan_break SHALL hold their values between scan_valid strobes.
REQ-024 scan_valid and frame_err SHALL never be asserted in the same cycle.

Reset
REQ-025 On reset, the FSM SHALL be in IDLE, the bit count 0, the timeout counter 0, and the flags clear.
REQ-026 On reset, the synchronizers and the filtered clock SHALL be set to 1 (bus idle).
REQ-027 On reset, scan_code SHALL be 0x00 and scan_ext, scan_break, scan_valid and frame_err SHALL be 0.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame and flags with no output strobe.

Structure
REQ-029 The shared package zircon_ps2_pkg SHALL hold the FSM state encoding and the constants PS2_PREFIX_EXT=0xE0 and PS2_PREFIX_BRK=0xF0.
REQ-030 The synchronizer and clock filter SHALL be one sub-module, zircon_ps2_filter, with a FILTER_LEN parameter; the FSM and event decoder SHALL stay in zircon_ps2_rx.

Verification
REQ-031 The bench SHALL drive a frame of byte 0x1C (A) with parity 0 and stop 1 -> exactly one scan_valid, with scan_code=0x1C, ext=0, brk=0, 2 cycles after the stop edge.
REQ-032 The bench SHALL drive the sequence E0, F0, 0x75 -> exactly one scan_valid, with scan_code=0x75, ext=1, brk=1; flags clear afterwards.
REQ-033 The bench SHALL drive 0x1C with parity 1 -> frame_err pulses once and there is no scan_valid; a following good 0x1C gives scan_valid with brk=0.
REQ-034 The bench SHALL drive F0 followed by 5 bits and then an idle clock longer than TIMEOUT_CYC -> one frame_err; a following 0x29 gives scan_valid with brk=0.
REQ-035 The bench SHALL add glitches shorter than FILTER_LEN cycles on coe_ps2_clk during a 0x5A frame -> scan_code=0x5A with no error.
REQ-036 The bench SHALL assert rsi_reset_n low after 4 data bits -> no strobe, all outputs at reset values; a following 0x16 frame decodes correctly.

Source files
------------

// File: rtl/zircon_ps2_pkg.sv
// Shared constants for the PS/2 receiver: frame FSM encoding, scan-code prefixes
// and the odd-parity helper.
package zircon_ps2_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  // Odd parity: data plus parity bit must carry an odd number of ones.
  function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/zircon_ps2_filter.sv
// Pin conditioning for PS/2: 2-flop synchronizers on clock and data, plus a
// level filter on the clock that ignores pulses shorter than FILTER_LEN cycles.
module zircon_ps2_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk_raw,
  input  logic ps2_data_raw,
  output logic ps2_clk_filt,
  output logic ps2_data_sync
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    clk_sync_q;
  logic [1:0]    data_sync_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive samples that disagree with the filtered level; flip on the FILTER_LEN-th.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      cnt_q       <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_raw};
      data_sync_q <= {data_sync_q[0], ps2_data_raw};
      filt_q      <= filt_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ps2_clk_filt  = filt_q;
  assign ps2_data_sync = data_sync_q[1];

endmodule

// File: rtl/zircon_ps2_rx.sv
// PS/2 keyboard receiver: frame FSM on filtered clock falling edges, followed by
// an event decoder that folds E0/F0 prefixes into one key event strobe.
module zircon_ps2_rx
  import zircon_ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       csi_clk,
  input  logic       rsi_reset_n,
  input  logic       coe_ps2_clk,
  input  logic       coe_ps2_data,
  output logic [7:0] scan_code,
  output logic       scan_ext,
  output logic       scan_break,
  output logic       scan_valid,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic ps2_clk_filt, ps2_data_sync;

  zircon_ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk          (csi_clk),
    .rst_n        (rsi_reset_n),
    .ps2_clk_raw  (coe_ps2_clk),
    .ps2_data_raw (coe_ps2_data),
    .ps2_clk_filt (ps2_clk_filt),
    .ps2_data_sync(ps2_data_sync)
  );

  logic          clk_prev_q;
  logic          fall;
  logic [1:0]    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] timeout_q, timeout_d;
  logic [7:0]    byte_q, byte_d;
  logic          byte_valid_q, byte_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          ext_q, ext_d, brk_q, brk_d;
  logic [7:0]    scan_code_q, scan_code_d;
  logic          scan_ext_q, scan_ext_d, scan_break_q, scan_break_d;
  logic          scan_valid_q, scan_valid_d;

  assign fall = clk_prev_q & ~ps2_clk_filt;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    timeout_d    = (state_q == ST_IDLE || fall) ? '0 : timeout_q + 1'b1;
    case (state_q)
      ST_IDLE: if (fall) begin
        if (!ps2_data_sync) begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'd0;
        end else begin
          frame_err_d = 1'b1;
        end
      end
      ST_DATA: if (fall) begin
        shift_d   = {ps2_data_sync, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
      end
      ST_PARITY: if (fall) begin
        parity_d = ps2_data_sync;
        state_d  = ST_STOP;
      end
      default: if (fall) begin
        state_d = ST_IDLE;
        if (ps2_data_sync && ps2_parity_ok(shift_q, parity_q)) begin
          byte_valid_d = 1'b1;
          byte_d       = shift_q;
        end else begin
          frame_err_d = 1'b1;
        end
      end
    endcase
    // A stalled partial frame is dropped so the next start bit is recognised.
    if (state_q != ST_IDLE && !fall && timeout_q == TW'(TIMEOUT_CYC - 1)) begin
      state_d     = ST_IDLE;
      bit_cnt_d   = 3'd0;
      timeout_d   = '0;
      frame_err_d = 1'b1;
    end
  end

  always_comb begin
    ext_d        = ext_q;
    brk_d        = brk_q;
    scan_code_d  = scan_code_q;
    scan_ext_d   = scan_ext_q;
    scan_break_d = scan_break_q;
    scan_valid_d = 1'b0;
    if (frame_err_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_valid_q) begin
      if (byte_q == PS2_PREFIX_EXT) begin
        ext_d = 1'b1;
      end else if (byte_q == PS2_PREFIX_BRK) begin
        brk_d = 1'b1;
      end else begin
        scan_code_d  = byte_q;
        scan_ext_d   = ext_q;
        scan_break_d = brk_q;
        scan_valid_d = 1'b1;
        ext_d        = 1'b0;
        brk_d        = 1'b0;
      end
    end
  end

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      clk_prev_q   <= 1'b1;
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      parity_q     <= 1'b0;
      timeout_q    <= '0;
      byte_q       <= 8'h00;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      scan_code_q  <= 8'h00;
      scan_ext_q   <= 1'b0;
      scan_break_q <= 1'b0;
      scan_valid_q <= 1'b0;
    end else begin
      clk_prev_q   <= ps2_clk_filt;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      timeout_q    <= timeout_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      scan_code_q  <= scan_code_d;
      scan_ext_q   <= scan_ext_d;
      scan_break_q <= scan_break_d;
      scan_valid_q <= scan_valid_d;
    end
  end

  assign scan_code  = scan_code_q;
  assign scan_ext   = scan_ext_q;
  assign scan_break = scan_break_q;
  assign scan_valid = scan_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_zircon_ps2_rx.sv
// Directed bench for zircon_ps2_rx: stimulus pushes expected events into a queue,
// a negedge monitor pops and compares each scan_valid / frame_err strobe.
module tb_zircon_ps2_rx;

  localparam int FL  = 4;
  localparam int TO  = 2000;
  localparam int LAT = FL + 4;  // posedges from raw stop-bit fall to visible scan_valid

  typedef struct {
    bit       is_err;
    bit [7:0] code;
    bit       ext;
    bit       brk;
    bit       chk_lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scan_code;
  logic       scan_ext, scan_break, scan_valid, frame_err;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   stop_cyc = 0;

  zircon_ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .csi_clk     (clk),
    .rsi_reset_n (rst_n),
    .coe_ps2_clk (ps2_clk),
    .coe_ps2_data(ps2_data),
    .scan_code   (scan_code),
    .scan_ext    (scan_ext),
    .scan_break  (scan_break),
    .scan_valid  (scan_valid),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_scan(input bit [7:0] code, input bit ext, input bit brk, input bit lat);
    exp_t e;
    e.is_err = 1'b0; e.code = code; e.ext = ext; e.brk = brk; e.chk_lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_err = 1'b1; e.code = 8'h00; e.ext = 1'b0; e.brk = 1'b0; e.chk_lat = 1'b0;
    exp_q.push_back(e);
  endtask

  // Drive the first nbits bits of a frame; each bit is 40 cycles, data set mid-high.
  task automatic send_frame(input bit [7:0] b, input bit par, input bit stp,
                            input int nbits, input bit glitch);
    bit [10:0] bits;
    bits = {stp, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk) ps2_data = bits[i];
      if (glitch) begin
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (FL - 2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10 - 4 - (FL - 2)) @(negedge clk);
      end else begin
        repeat (10) @(negedge clk);
      end
      ps2_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      if (glitch) begin
        repeat (8) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (FL - 2) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (20 - 8 - (FL - 2)) @(negedge clk);
      end else begin
        repeat (20) @(negedge clk);
      end
      ps2_clk = 1'b1;
      repeat (9) @(negedge clk);
    end
    repeat (30) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_code"}, scan_code, 0);
    check({tag, "_ext"}, scan_ext, 0);
    check({tag, "_brk"}, scan_break, 0);
    check({tag, "_valid"}, scan_valid, 0);
    check({tag, "_err"}, frame_err, 0);
  endtask

  always @(negedge clk) begin
    if (scan_valid || frame_err) begin
      exp_t e;
      check("strobe_exclusive", int'(scan_valid && frame_err), 0);
      if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL unexpected_strobe: got valid=%0b err=%0b code=0x%0h, expected none",
                 scan_valid, frame_err, scan_code);
      end else begin
        e = exp_q.pop_front();
        check("strobe_kind", int'(frame_err), int'(e.is_err));
        if (!e.is_err) begin
          check("scan_code", scan_code, e.code);
          check("scan_ext", scan_ext, e.ext);
          check("scan_break", scan_break, e.brk);
          $display("event: code=0x%02h ext=%0b brk=%0b", scan_code, scan_ext, scan_break);
          if (e.chk_lat) check("latency", cyc - stop_cyc, LAT);
        end else begin
          $display("event: frame_err");
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Plain make code with latency check.
    expect_scan(8'h1C, 1'b0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);

    // Extended break: E0 F0 75, then a plain key to show flags were cleared.
    expect_scan(8'h75, 1'b1, 1'b1, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b1, 11, 1'b0);
    send_frame(8'hF0, 1'b1, 1'b1, 11, 1'b0);
    send_frame(8'h75, 1'b0, 1'b1, 11, 1'b0);
    expect_scan(8'h1C, 1'b0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);

    // Bad parity after an F0 prefix: error clears brk.
    send_frame(8'hF0, 1'b1, 1'b1, 11, 1'b0);
    expect_err();
    send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0);
    expect_scan(8'h1C, 1'b0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);

    // Bad stop bit.
    expect_err();
    send_frame(8'h33, 1'b1, 1'b0, 11, 1'b0);

    // Timeout: F0, then start + 5 data bits and a long idle clock.
    send_frame(8'hF0, 1'b1, 1'b1, 11, 1'b0);
    expect_err();
    send_frame(8'h00, 1'b0, 1'b1, 6, 1'b0);
    repeat (TO + 300) @(negedge clk);
    expect_scan(8'h29, 1'b0, 1'b0, 1'b0);
    send_frame(8'h29, 1'b0, 1'b1, 11, 1'b0);

    // Short glitches on the clock in both levels.
    expect_scan(8'h5A, 1'b0, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b1, 11, 1'b1);

    // Reset in mid-frame after 4 data bits.
    send_frame(8'h16, 1'b0, 1'b1, 5, 1'b0);
    @(negedge clk) rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check_reset_outputs("postreset");
    expect_scan(8'h16, 1'b0, 1'b0, 1'b0);
    send_frame(8'h16, 1'b0, 1'b1, 11, 1'b0);

    repeat (50) @(negedge clk);
    check("pending_events", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
